aemb2_dwb_ctrl: RTL and testbench

Data-side bus controller for the AEMB2 core: the consumer of the integer unit's load/store effective address (mem_ex) and store data. It converts one EX-stage load/store into a single classic Wishbone master cycle, stalls the pipeline via dwb_fb while the cycle is outstanding, and returns byte-lane-aligned, zero-extended load data to the MX stage. Big-endian (MicroBlaze) lane ordering; one outstanding transfer; bus-timeout watchdog.

---
 rtl/aemb2_dwb_if.sv | 22 ++
 rtl/aemb2_dwb_ctrl.sv | 172 +++++++++++++++++
 tb/tb_aemb2_dwb_ctrl.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/aemb2_dwb_if.sv
// Wishbone data-bus bundle between the AEMB2 data controller (master) and
// the memory/peripheral fabric (slave).
interface aemb2_dwb_if;
   logic [29:0] dwb_adr_o;
   logic [3:0]  dwb_sel_o;
   logic [31:0] dwb_dat_o;
   logic        dwb_wre_o;
   logic        dwb_stb_o;
   logic        dwb_cyc_o;
   logic        dwb_ack_i;
   logic [31:0] dwb_dat_i;

   modport master (
      output dwb_adr_o, dwb_sel_o, dwb_dat_o, dwb_wre_o, dwb_stb_o, dwb_cyc_o,
      input  dwb_ack_i, dwb_dat_i
   );

   modport slave (
      input  dwb_adr_o, dwb_sel_o, dwb_dat_o, dwb_wre_o, dwb_stb_o, dwb_cyc_o,
      output dwb_ack_i, dwb_dat_i
   );
endinterface

// File: rtl/aemb2_dwb_ctrl.sv
// AEMB2 data-side bus controller: one EX load/store becomes one classic
// Wishbone cycle, with pipeline stall, big-endian lane alignment and timeout.
module aemb2_dwb_ctrl #(
   parameter int AEMB_DWB = 32,
   parameter int AEMB_TMO = 255
) (
   input  logic              gclk,
   input  logic              grst,
   input  logic              dena,
   input  logic              req_ex,
   input  logic              wre_ex,
   input  logic [1:0]        siz_ex,
   input  logic [1:0]        ofs_ex,
   input  logic [29:0]       mem_ex,
   input  logic [31:0]       dat_ex,
   aemb2_dwb_if.master       dwb,
   output logic              dwb_fb,
   output logic [31:0]       dat_mx,
   output logic              dwb_err
);

   typedef enum logic {IDLE, BUSY} state_t;

   localparam logic [29:0] ADR_MASK = 30'h3FFF_FFFF >> (32 - AEMB_DWB);
   localparam logic [9:0]  TMO      = 10'(AEMB_TMO);

   state_t      state_q, state_d;
   logic [29:0] adr_q, adr_d;
   logic [3:0]  sel_q, sel_d;
   logic [31:0] dat_o_q, dat_o_d;
   logic        wre_q, wre_d;
   logic        stb_q, stb_d;
   logic        cyc_q, cyc_d;
   logic        fb_q, fb_d;
   logic [31:0] dat_mx_q, dat_mx_d;
   logic        err_q, err_d;
   logic [1:0]  siz_q, siz_d;
   logic [1:0]  ofs_q, ofs_d;
   logic [9:0]  cnt_q, cnt_d;

   logic [3:0]  sel_req;
   logic [31:0] st_dat;
   logic [31:0] ld_dat;

   // Lane 3 is bits [31:24]: lowest byte address on the most significant lane.
   always_comb begin
      sel_req = 4'b1111;
      case (siz_ex)
         2'b00:   sel_req = 4'b1000 >> ofs_ex;
         2'b01:   sel_req = ofs_ex[1] ? 4'b0011 : 4'b1100;
         default: sel_req = 4'b1111;
      endcase
   end

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         assign st_dat[8*gi +: 8] = (siz_ex == 2'b00) ? dat_ex[7:0] :
                                    (siz_ex == 2'b01) ? dat_ex[8*(gi%2) +: 8] :
                                                        dat_ex[8*gi +: 8];
      end
   endgenerate

   // Alignment uses size/offset captured at request, not the live EX values.
   always_comb begin
      ld_dat = dwb.dwb_dat_i;
      case (siz_q)
         2'b00:   ld_dat = {24'h0, dwb.dwb_dat_i[{~ofs_q, 3'b000} +: 8]};
         2'b01:   ld_dat = ofs_q[1] ? {16'h0, dwb.dwb_dat_i[15:0]}
                                    : {16'h0, dwb.dwb_dat_i[31:16]};
         default: ld_dat = dwb.dwb_dat_i;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      adr_d    = adr_q;
      sel_d    = sel_q;
      dat_o_d  = dat_o_q;
      wre_d    = wre_q;
      stb_d    = stb_q;
      cyc_d    = cyc_q;
      fb_d     = fb_q;
      dat_mx_d = dat_mx_q;
      err_d    = err_q;
      siz_d    = siz_q;
      ofs_d    = ofs_q;
      cnt_d    = cnt_q;
      case (state_q)
         IDLE: begin
            if (dena && req_ex) begin
               state_d = BUSY;
               adr_d   = mem_ex & ADR_MASK;
               sel_d   = sel_req;
               dat_o_d = st_dat;
               wre_d   = wre_ex;
               siz_d   = siz_ex;
               ofs_d   = ofs_ex;
               stb_d   = 1'b1;
               cyc_d   = 1'b1;
               fb_d    = 1'b0;
               cnt_d   = 10'd0;
            end
         end
         BUSY: begin
            if (dwb.dwb_ack_i) begin
               state_d = IDLE;
               stb_d   = 1'b0;
               cyc_d   = 1'b0;
               wre_d   = 1'b0;
               fb_d    = 1'b1;
               if (!wre_q) dat_mx_d = ld_dat;
            end else if (cnt_q == TMO) begin
               // Abandon the cycle; loads see an all-ones poison value.
               state_d = IDLE;
               stb_d   = 1'b0;
               cyc_d   = 1'b0;
               wre_d   = 1'b0;
               fb_d    = 1'b1;
               err_d   = 1'b1;
               if (!wre_q) dat_mx_d = 32'hFFFF_FFFF;
            end else begin
               cnt_d = cnt_q + 10'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge gclk) begin
      if (grst) begin
         state_q  <= IDLE;
         adr_q    <= '0;
         sel_q    <= '0;
         dat_o_q  <= '0;
         wre_q    <= 1'b0;
         stb_q    <= 1'b0;
         cyc_q    <= 1'b0;
         fb_q     <= 1'b1;
         dat_mx_q <= '0;
         err_q    <= 1'b0;
         siz_q    <= '0;
         ofs_q    <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         adr_q    <= adr_d;
         sel_q    <= sel_d;
         dat_o_q  <= dat_o_d;
         wre_q    <= wre_d;
         stb_q    <= stb_d;
         cyc_q    <= cyc_d;
         fb_q     <= fb_d;
         dat_mx_q <= dat_mx_d;
         err_q    <= err_d;
         siz_q    <= siz_d;
         ofs_q    <= ofs_d;
         cnt_q    <= cnt_d;
      end
   end

   assign dwb.dwb_adr_o = adr_q;
   assign dwb.dwb_sel_o = sel_q;
   assign dwb.dwb_dat_o = dat_o_q;
   assign dwb.dwb_wre_o = wre_q;
   assign dwb.dwb_stb_o = stb_q;
   assign dwb.dwb_cyc_o = cyc_q;
   assign dwb_fb        = fb_q;
   assign dat_mx        = dat_mx_q;
   assign dwb_err       = err_q;

endmodule

// File: tb/tb_aemb2_dwb_ctrl.sv
// Randomized transaction bench for aemb2_dwb_ctrl with a transaction-level
// reference model and a per-cycle output compare.
module tb_aemb2_dwb_ctrl;
   localparam int TMO = 4;

   logic        gclk;
   logic        grst;
   logic        dena;
   logic        req_ex;
   logic        wre_ex;
   logic [1:0]  siz_ex;
   logic [1:0]  ofs_ex;
   logic [29:0] mem_ex;
   logic [31:0] dat_ex;
   logic        dwb_fb;
   logic [31:0] dat_mx;
   logic        dwb_err;

   aemb2_dwb_if dwb ();

   aemb2_dwb_ctrl #(.AEMB_DWB(32), .AEMB_TMO(TMO)) dut (
      .gclk(gclk), .grst(grst), .dena(dena), .req_ex(req_ex), .wre_ex(wre_ex),
      .siz_ex(siz_ex), .ofs_ex(ofs_ex), .mem_ex(mem_ex), .dat_ex(dat_ex),
      .dwb(dwb), .dwb_fb(dwb_fb), .dat_mx(dat_mx), .dwb_err(dwb_err)
   );

   initial gclk = 1'b0;
   always #5 gclk = ~gclk;

   int n_vec = 0;
   int n_bad = 0;

   // Reference expectations
   logic        chk_on = 1'b0;
   logic        exp_stb, exp_fb, exp_wre, exp_err;
   logic [29:0] exp_adr;
   logic [3:0]  exp_sel;
   logic [31:0] exp_dato, exp_dat_mx;

   function automatic logic [3:0] m_sel(input logic [1:0] sz, input logic [1:0] of);
      if (sz == 2'd0) return 4'(1 << (3 - int'(of)));
      if (sz == 2'd1) return (of >= 2'd2) ? 4'd3 : 4'd12;
      return 4'd15;
   endfunction

   function automatic logic [31:0] m_st(input logic [1:0] sz, input logic [31:0] d);
      if (sz == 2'd0) return (d & 32'hFF) * 32'h0101_0101;
      if (sz == 2'd1) return (d & 32'hFFFF) * 32'h0001_0001;
      return d;
   endfunction

   function automatic logic [31:0] m_ld(input logic [1:0] sz, input logic [1:0] of,
                                        input logic [31:0] di);
      if (sz == 2'd0) return (di >> (8 * (3 - int'(of)))) & 32'hFF;
      if (sz == 2'd1) return (di >> ((of >= 2'd2) ? 0 : 16)) & 32'hFFFF;
      return di;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_vec++;
      if (act !== expv) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
      end
   endtask

   always @(negedge gclk) begin
      if (chk_on) begin
         chk("stb", 32'(dwb.dwb_stb_o), 32'(exp_stb));
         chk("cyc", 32'(dwb.dwb_cyc_o), 32'(exp_stb));
         chk("fb", 32'(dwb_fb), 32'(exp_fb));
         chk("dat_mx", dat_mx, exp_dat_mx);
         chk("err", 32'(dwb_err), 32'(exp_err));
         if (exp_stb) begin
            chk("adr", 32'(dwb.dwb_adr_o), 32'(exp_adr));
            chk("sel", 32'(dwb.dwb_sel_o), 32'(exp_sel));
            chk("dat_o", dwb.dwb_dat_o, exp_dato);
            chk("wre", 32'(dwb.dwb_wre_o), 32'(exp_wre));
         end
      end
   end

   task automatic step();
      @(posedge gclk);
      #1;
   endtask

   task automatic scramble_ex();
      wre_ex = 1'($urandom);
      siz_ex = 2'($urandom);
      ofs_ex = 2'($urandom);
      mem_ex = 30'($urandom);
      dat_ex = $urandom;
   endtask

   // One transaction: idle gap, request edge, busy phase with ack after k
   // wait cycles (k > TMO means the bus never answers).
   task automatic run_txn(input logic w, input logic [1:0] sz, input logic [1:0] of,
                          input logic [29:0] a, input logic [31:0] d,
                          input logic [31:0] di, input int k, input int gap,
                          output int stall);
      stall = 0;
      for (int g = 0; g < gap; g++) begin
         dena   = 1'($urandom);
         req_ex = dena ? 1'b0 : 1'($urandom);
         scramble_ex();
         dwb.dwb_ack_i = 1'($urandom);
         dwb.dwb_dat_i = $urandom;
         step();
      end
      dena = 1'b1; req_ex = 1'b1;
      wre_ex = w; siz_ex = sz; ofs_ex = of; mem_ex = a; dat_ex = d;
      dwb.dwb_ack_i = 1'($urandom);
      dwb.dwb_dat_i = $urandom;
      step();
      exp_stb = 1'b1; exp_fb = 1'b0;
      exp_adr = a; exp_sel = m_sel(sz, of); exp_dato = m_st(sz, d); exp_wre = w;
      if (!dwb_fb) stall++;
      for (int i = 0; i <= TMO; i++) begin
         dena   = 1'($urandom);
         req_ex = 1'($urandom);
         scramble_ex();
         dwb.dwb_ack_i = (i == k);
         dwb.dwb_dat_i = (i == k) ? di : $urandom;
         step();
         if (i == k) begin
            exp_stb = 1'b0; exp_fb = 1'b1;
            if (!w) exp_dat_mx = m_ld(sz, of, di);
            break;
         end
         if (i == TMO) begin
            exp_stb = 1'b0; exp_fb = 1'b1; exp_err = 1'b1;
            if (!w) exp_dat_mx = 32'hFFFF_FFFF;
            break;
         end
         if (!dwb_fb) stall++;
      end
      dwb.dwb_ack_i = 1'b0;
      req_ex = 1'b0;
   endtask

   task automatic set_reset_exp();
      exp_stb = 1'b0; exp_fb = 1'b1; exp_dat_mx = '0; exp_err = 1'b0;
      exp_wre = 1'b0; exp_adr = '0; exp_sel = '0; exp_dato = '0;
   endtask

   initial begin
      int st;
      grst = 1'b1; dena = 1'b0; req_ex = 1'b0;
      wre_ex = 1'b0; siz_ex = '0; ofs_ex = '0; mem_ex = '0; dat_ex = '0;
      dwb.dwb_ack_i = 1'b0; dwb.dwb_dat_i = '0;
      set_reset_exp();
      step(); step(); step();
      chk_on = 1'b1;
      chk("rst_adr", 32'(dwb.dwb_adr_o), 32'h0);
      chk("rst_sel", 32'(dwb.dwb_sel_o), 32'h0);
      chk("rst_dat_o", dwb.dwb_dat_o, 32'h0);
      chk("rst_wre", 32'(dwb.dwb_wre_o), 32'h0);
      chk("rst_fb", 32'(dwb_fb), 32'h1);
      grst = 1'b0;
      step();

      // Directed cases with hand-computed results
      run_txn(1'b0, 2'b10, 2'd0, 30'h0000_0400, 32'h0, 32'hDEADBEEF, 0, 1, st);
      chk("wl_stall", 32'(st), 32'd1);
      chk("wl_dat_mx", dat_mx, 32'hDEADBEEF);
      run_txn(1'b1, 2'b00, 2'd2, 30'h0000_0123, 32'h0000_00A5, 32'h0, 3, 1, st);
      chk("bs_stall", 32'(st), 32'd4);
      chk("bs_dat_mx", dat_mx, 32'hDEADBEEF);
      run_txn(1'b0, 2'b01, 2'd2, 30'h10, 32'h0, 32'h1234_5678, 1, 0, st);
      chk("hl2_dat_mx", dat_mx, 32'h0000_5678);
      run_txn(1'b0, 2'b01, 2'd0, 30'h11, 32'h0, 32'h1234_5678, 0, 0, st);
      chk("hl0_dat_mx", dat_mx, 32'h0000_1234);
      run_txn(1'b0, 2'b00, 2'd1, 30'h12, 32'h0, 32'h1234_5678, 2, 0, st);
      chk("bl1_dat_mx", dat_mx, 32'h0000_0034);
      run_txn(1'b0, 2'b10, 2'd0, 30'h20, 32'h0, 32'h0, 99, 1, st);
      chk("tmo_stall", 32'(st), 32'd5);
      chk("tmo_err", 32'(dwb_err), 32'h1);
      chk("tmo_dat_mx", dat_mx, 32'hFFFF_FFFF);
      run_txn(1'b0, 2'b10, 2'd0, 30'h21, 32'h0, 32'h0BAD_F00D, 1, 0, st);
      chk("post_tmo_err", 32'(dwb_err), 32'h1);
      chk("post_tmo_dat", dat_mx, 32'h0BAD_F00D);
      run_txn(1'b0, 2'b10, 2'd0, 30'h22, 32'h0, 32'hCAFE_0001, TMO, 0, st);
      chk("ack_at_tmo_dat", dat_mx, 32'hCAFE_0001);

      // Reset during the second busy cycle, then a late ack
      dena = 1'b1; req_ex = 1'b1; wre_ex = 1'b0; siz_ex = 2'b10; ofs_ex = 2'd0;
      mem_ex = 30'h30; dat_ex = '0;
      step();
      exp_stb = 1'b1; exp_fb = 1'b0; exp_adr = 30'h30; exp_sel = 4'hF;
      exp_dato = '0; exp_wre = 1'b0;
      req_ex = 1'b0;
      step();
      grst = 1'b1;
      step();
      set_reset_exp();
      grst = 1'b0; dwb.dwb_ack_i = 1'b1; dwb.dwb_dat_i = 32'h5555_AAAA;
      step();
      dwb.dwb_ack_i = 1'b0;
      chk("rst_mid_stb", 32'(dwb.dwb_stb_o), 32'h0);
      chk("rst_mid_fb", 32'(dwb_fb), 32'h1);
      chk("rst_mid_dat", dat_mx, 32'h0);
      chk("rst_mid_err", 32'(dwb_err), 32'h0);

      // Randomized traffic
      for (int t = 0; t < 400; t++) begin
         run_txn(1'($urandom), 2'($urandom), 2'($urandom), 30'($urandom), $urandom,
                 $urandom, int'($urandom_range(0, 6)), int'($urandom_range(0, 3)), st);
      end
      step();
      chk_on = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
